calculator_entry: RTL and testbench
===================================

Name: calculator_entry

Overview:
- Sequential operand-entry front end for the two-operand, 5-bit add/multiply calculator display stage; sits directly upstream of it.
- Samples board switches and two raw push-buttons (enter, clear).
- Steps through an entry state machine that captures in0, in1 and op.
- Drives registered in0/in1/op to the downstream display stage, plus a phase indicator and a result-valid flag.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a button level must hold before it is accepted. Must be >= 1; the board top sets a large value.
- WIDTH, 5, operand width. Must match the display stage.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- sw  in  WIDTH  operand switches; sampled only on an accepted enter press.
- op_sw  in  1  0 = add, 1 = multiply; sampled together with in1.
- btn_enter  in  1  raw asynchronous enter button, active-high.
- btn_clear  in  1  raw asynchronous clear button, active-high.
- in0  out  WIDTH  registered operand 0 to the display stage.
- in1  out  WIDTH  registered operand 1 to the display stage.
- op  out  1  registered operator to the display stage.
- phase  out  2  current FSM state encoding.
- result_valid  out  1  1 only in state SHOW.

Behaviour:
- Reset (async assert, sync-free deassert): in0=0, in1=0, op=0, phase=ENTER_IN0 (2'b00), result_valid=0. Synchronizers, debounce counters and accepted levels are all 0.
- Button path, per button:
  - Two-flop synchronizer.
  - Debouncer: counter increments on each edge where the synchronized level differs from the accepted level, and clears when they are equal. On the DEBOUNCE_CYCLES-th consecutive differing edge, the accepted level flips and the counter clears.
  - A one-cycle press pulse is generated on a 0->1 transition of the accepted level. Releases are debounced but produce no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- Latency: raw button held high from before edge 1 -> accepted level flips at edge 2+DEBOUNCE_CYCLES -> FSM/output registers update at edge 3+DEBOUNCE_CYCLES (edge 7 at default).
- Holding a button produces exactly one press.
- FSM states: ENTER_IN0=00, ENTER_IN1=01, SHOW=10. Code 11 is unreachable and recovers to ENTER_IN0 with all outputs cleared.
  - ENTER_IN0 + enter press: in0<=sw; go to ENTER_IN1.
  - ENTER_IN1 + enter press: in1<=sw, op<=op_sw; go to SHOW.
  - SHOW + enter press: in0<=sw, in1<=0, op<=0; go to ENTER_IN1 (starts a new calculation).
  - Any state + clear press: in0, in1, op <= 0; go to ENTER_IN0.
- Simultaneous enter and clear pulses in the same cycle: clear wins; enter is discarded.
- Switch changes without a press have no effect on the outputs.
- result_valid and phase are decoded from the state register, so they change in the same cycle as the state.
- Reset asserted mid-debounce or mid-entry immediately forces the reset values. A button still held at deassertion is seen as a new press after the full latency.
- Widths: debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits; no arithmetic on operands.

Decomposition:
- Package calculator_pkg:
  - WIDTH constant.
  - State enum typedef with encodings ENTER_IN0/ENTER_IN1/SHOW.
  - Op encoding constants OP_ADD=0, OP_MUL=1.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_raw, press). Contains synchronizer, debounce counter and rise detector; instantiated twice.
- Top block holds the FSM and operand registers only.

Test Plan:
- Reset then idle 10 cycles, sw=5'd9 -> in0=0, in1=0, op=0, phase=00, result_valid=0 throughout.
- sw=5'd3, hold enter 10 cycles from edge 0 -> in0=3 and phase=01 first visible after edge 7; no second capture while held.
- Continue: release, then sw=5'd12, op_sw=1, enter -> in1=12, op=1, phase=10, result_valid=1. Further sw changes leave in0=3, in1=12 unchanged.
- Enter glitch high for 3 synchronized cycles (DEBOUNCE_CYCLES=4) -> no state or output change.
- In SHOW with sw=5'd7, press enter -> in0=7, in1=0, op=0, phase=01. Then raise clear and enter on the same edge and hold -> phase=00, all operands 0, no capture.
- Drive reset low while enter held mid-debounce (cycle 4) -> outputs at reset values immediately. After deassertion with enter still held, exactly one capture occurs 7 edges later.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared constants and state encoding for the calculator operand-entry front end.
package calculator_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    ENTER_IN0 = 2'b00,
    ENTER_IN1 = 2'b01,
    SHOW      = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, level debouncer and
// single-cycle press pulse on an accepted 0->1 transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/calculator_entry.sv
// Operand-entry state machine feeding the add/multiply display stage: captures
// in0, then in1 and op, on debounced enter presses; clear returns to the start.
module calculator_entry
  import calculator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = calculator_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic             op,
  output logic [1:0]       phase,
  output logic             result_valid
);

  logic             enter_press;
  logic             clear_press;
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] in0_next;
  logic [WIDTH-1:0] in1_next;
  logic             op_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_enter),
    .press   (enter_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clear),
    .press   (clear_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ENTER_IN0;
      in0   <= '0;
      in1   <= '0;
      op    <= OP_ADD;
    end else begin
      state <= state_next;
      in0   <= in0_next;
      in1   <= in1_next;
      op    <= op_next;
    end
  end

  always_comb begin
    state_next = state;
    in0_next   = in0;
    in1_next   = in1;
    op_next    = op;
    case (state)
      ENTER_IN0: begin
        if (enter_press) begin
          in0_next   = sw;
          state_next = ENTER_IN1;
        end
      end
      ENTER_IN1: begin
        if (enter_press) begin
          in1_next   = sw;
          op_next    = op_sw;
          state_next = SHOW;
        end
      end
      SHOW: begin
        // A new enter while showing a result starts the next calculation
        if (enter_press) begin
          in0_next   = sw;
          in1_next   = '0;
          op_next    = OP_ADD;
          state_next = ENTER_IN1;
        end
      end
      default: begin
        in0_next   = '0;
        in1_next   = '0;
        op_next    = OP_ADD;
        state_next = ENTER_IN0;
      end
    endcase
    // Clear overrides any simultaneous enter
    if (clear_press) begin
      in0_next   = '0;
      in1_next   = '0;
      op_next    = OP_ADD;
      state_next = ENTER_IN0;
    end
  end

  assign phase        = state;
  assign result_valid = (state == SHOW);

endmodule

// File: tb/tb_calculator_entry.sv
// Bench for calculator_entry: fixed vector table, hand-written latency/reset
// sequences and randomized button activity checked against a window-based model.
module tb_calculator_entry;

  localparam int D    = 4;
  localparam int W    = 5;
  localparam int HMAX = 16384;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw = '0;
  logic         op_sw = 1'b0;
  logic         btn_enter = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         op;
  logic [1:0]   phase;
  logic         result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  calculator_entry #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .op_sw        (op_sw),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .in0          (in0),
    .in1          (in1),
    .op           (op),
    .phase        (phase),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Reference model: raw button history per edge; a button's accepted level flips
  // when the last D synchronized samples (raw delayed two edges) all disagree with it.
  bit           raw_hist [2][HMAX];
  bit           acc [2];
  bit           pend [2];
  int           e;
  logic [W-1:0] m_in0;
  logic [W-1:0] m_in1;
  logic         m_op;
  logic [1:0]   m_phase;

  function automatic void model_reset();
    e = 0;
    for (int b = 0; b < 2; b++) begin
      acc[b]  = 1'b0;
      pend[b] = 1'b0;
    end
    m_in0 = '0; m_in1 = '0; m_op = 1'b0; m_phase = 2'd0;
  endfunction

  function automatic bit sync_at(int b, int k);
    if (k < 3) return 1'b0;
    return raw_hist[b][k-2];
  endfunction

  function automatic void model_edge();
    bit flip;
    if (!reset) begin
      model_reset();
      return;
    end
    e++;
    if (pend[1]) begin
      m_in0 = '0; m_in1 = '0; m_op = 1'b0; m_phase = 2'd0;
    end else if (pend[0]) begin
      if (m_phase == 2'd0) begin
        m_in0 = sw; m_phase = 2'd1;
      end else if (m_phase == 2'd1) begin
        m_in1 = sw; m_op = op_sw; m_phase = 2'd2;
      end else begin
        m_in0 = sw; m_in1 = '0; m_op = 1'b0; m_phase = 2'd1;
      end
    end
    raw_hist[0][e] = btn_enter;
    raw_hist[1][e] = btn_clear;
    for (int b = 0; b < 2; b++) begin
      pend[b] = 1'b0;
      flip = 1'b1;
      for (int j = 0; j < D; j++)
        if (sync_at(b, e - j) == acc[b]) flip = 1'b0;
      if (flip) begin
        acc[b]  = ~acc[b];
        pend[b] = acc[b];
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk(name, int'({in0, in1, op, phase, result_valid}),
        int'({m_in0, m_in1, m_op, m_phase, (m_phase == 2'd2)}));
  endtask

  task automatic cycle(input logic [W-1:0] s, input bit o, input bit en, input bit cl);
    @(negedge clk);
    sw = s; op_sw = o; btn_enter = en; btn_clear = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_model("model");
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in0"}, int'(in0), 0);
    chk({name, "_in1"}, int'(in1), 0);
    chk({name, "_op"}, int'(op), 0);
    chk({name, "_phase"}, int'(phase), 0);
    chk({name, "_rv"}, int'(result_valid), 0);
  endtask

  typedef struct {
    logic [W-1:0] sw;
    bit           op_sw;
    bit           en;
    bit           cl;
    int           hold;
    int           rel;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    bit           xop;
    logic [1:0]   xph;
    bit           xrv;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int len_e;
    int lev_e;
    int lev_c;

    model_reset();
    #12;
    chk_reset_vals("reset");
    reset = 1'b1;

    // Latency: enter held from before edge 1 is acted on at edge 7, once
    for (int i = 1; i <= 10; i++) begin
      cycle((i >= 8) ? 5'd17 : 5'd3, 1'b0, 1'b1, 1'b0);
      if (i < 7) chk($sformatf("lat_pre%0d", i), int'({in0, phase}), int'({5'd0, 2'd0}));
      else       chk($sformatf("lat_post%0d", i), int'({in0, phase}), int'({5'd3, 2'd1}));
    end
    repeat (12) cycle(5'd17, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a debounce, enter still held through deassertion
    repeat (4) cycle(5'd20, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    repeat (3) cycle(5'd20, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle(5'd20, 1'b0, 1'b1, 1'b0);
      if (i < 7) chk($sformatf("rst_pre%0d", i), int'({in0, phase}), int'({5'd0, 2'd0}));
      else       chk($sformatf("rst_post%0d", i), int'({in0, phase}), int'({5'd20, 2'd1}));
    end
    repeat (12) cycle(5'd20, 1'b0, 1'b0, 1'b0);

    #1;
    reset = 1'b0;
    model_reset();
    repeat (2) cycle(5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;

    tbl[0] = '{5'd9,  1'b0, 1'b0, 1'b0, 10, 0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0};
    tbl[1] = '{5'd3,  1'b0, 1'b1, 1'b0, 10, 12, 5'd3, 5'd0,  1'b0, 2'b01, 1'b0};
    tbl[2] = '{5'd12, 1'b1, 1'b1, 1'b0, 10, 12, 5'd3, 5'd12, 1'b1, 2'b10, 1'b1};
    tbl[3] = '{5'd21, 1'b0, 1'b0, 1'b0, 10, 0,  5'd3, 5'd12, 1'b1, 2'b10, 1'b1};
    tbl[4] = '{5'd30, 1'b0, 1'b1, 1'b0, 3,  12, 5'd3, 5'd12, 1'b1, 2'b10, 1'b1};
    tbl[5] = '{5'd7,  1'b1, 1'b1, 1'b0, 10, 12, 5'd7, 5'd0,  1'b0, 2'b01, 1'b0};
    tbl[6] = '{5'd25, 1'b1, 1'b1, 1'b1, 10, 12, 5'd0, 5'd0,  1'b0, 2'b00, 1'b0};
    tbl[7] = '{5'd31, 1'b1, 1'b0, 1'b1, 10, 12, 5'd0, 5'd0,  1'b0, 2'b00, 1'b0};

    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < tbl[v].hold; c++) cycle(tbl[v].sw, tbl[v].op_sw, tbl[v].en, tbl[v].cl);
      for (int c = 0; c < tbl[v].rel; c++)  cycle(tbl[v].sw, tbl[v].op_sw, 1'b0, 1'b0);
      chk($sformatf("vec%0d_in0", v), int'(in0), int'(tbl[v].x0));
      chk($sformatf("vec%0d_in1", v), int'(in1), int'(tbl[v].x1));
      chk($sformatf("vec%0d_op", v), int'(op), int'(tbl[v].xop));
      chk($sformatf("vec%0d_phase", v), int'(phase), int'(tbl[v].xph));
      chk($sformatf("vec%0d_rv", v), int'(result_valid), int'(tbl[v].xrv));
    end

    // Randomized button activity with mixed hold lengths, compared every cycle
    len_e = 0;
    lev_e = 0;
    for (int i = 0; i < 3000; i++) begin
      if (len_e == 0) begin
        lev_e = $urandom_range(0, 1);
        len_e = $urandom_range(1, 12);
      end
      len_e--;
      lev_c = ($urandom_range(0, 9) == 0) ? 1 : ((i % 97) < 8 ? 1 : 0);
      cycle(W'($urandom), 1'($urandom), 1'(lev_e), 1'(lev_c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
